ref_column_feeder: RTL and testbench
====================================

# ref_column_feeder

Reference-window column streamer that drives the 184-bit column input of the motion-estimation reference FIFO. On a start command it reads a 23×23-pixel search window from the reference frame memory one pixel per cycle, packs each vertical 23-pixel column into a 184-bit word, and hands the columns to the FIFO over a valid/ready handshake, left to right. It is the writer end of the FIFO's `data_in` column interface.

## Interface
- `BIT_DEPTH`, 8, bits per pixel
- `COL_PIXELS`, 23, pixels per column (8-pixel block edge + 15 vertical search offsets)
- `NUM_COLS`, 23, columns per window (8 + 15 horizontal offsets)
- `FRAME_WIDTH_LOG2`, 6, log2 of frame width in pixels (64)
- `ADDR_WIDTH`, 12, frame memory address width
- `clk_i`  in  1  clock, all state on rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `start_i`  in  1  start request, sampled only in IDLE
- `x0_i`  in  FRAME_WIDTH_LOG2  window left column, sampled with `start_i`
- `y0_i`  in  ADDR_WIDTH-FRAME_WIDTH_LOG2  window top row, sampled with `start_i`
- `busy_o`  out  1  high in any state other than IDLE
- `done_o`  out  1  one-cycle pulse after the last column transfers
- `mem_rd_en_o`  out  1  frame memory read strobe
- `mem_addr_o`  out  ADDR_WIDTH  read address = ((y0+r) << FRAME_WIDTH_LOG2) + x0 + c
- `mem_data_i`  in  BIT_DEPTH  read data, valid exactly one cycle after `mem_rd_en_o`
- `col_valid_o`  out  1  column word valid
- `col_ready_i`  in  1  FIFO accepts column
- `col_data_o`  out  COL_PIXELS*BIT_DEPTH  packed column, row 0 in bits [183:176], row 22 in [7:0]
- `col_index_o`  out  5  column number c (0..22) of the word on `col_data_o`

## Operation
- States: IDLE, FETCH, HOLD, DONE.
- IDLE: `start_i`=1 latches x0/y0, clears c and r, goes to FETCH. Otherwise stays.
- FETCH: `mem_rd_en_o`=1 while r<23, address for (r,c), r increments. Returning data shifts into the column register from the LSB end (shift left by BIT_DEPTH), so row 0 ends in the MSB byte. When the 23rd pixel is captured, `col_valid_o` is set and the state goes to HOLD.
- HOLD: `col_data_o` and `col_index_o` stay stable until `col_valid_o & col_ready_i`. On transfer: if c<22, c increments, r clears, and the state goes to FETCH. If c=22, the state goes to DONE. `col_valid_o` clears on transfer.
- DONE: `done_o`=1 for one cycle, then IDLE.
- `start_i` is ignored outside IDLE. `start_i` in the DONE cycle is not queued.
- Address arithmetic is modulo 2^ADDR_WIDTH with no clamping. The caller guarantees the window lies inside the frame.
- `rst_i` at any time clears every register asynchronously and returns to IDLE. In-flight memory data is discarded and a partial column is never emitted.
- Reset values: all outputs 0, state IDLE.

## Timing
- Edge E0 samples `start_i`.
- `mem_rd_en_o` is high in the 23 cycles following E0..E22, rows 0..22 in order.
- The last pixel is captured at E24, and `col_valid_o` is high from E24.
- With `col_ready_i` held high, the transfer occurs at E25, and the next column's first read is in the cycle after E25. The column period is 25 cycles.
- A window with no backpressure takes 23×25 = 575 cycles to the last transfer edge. `done_o` is high in the following cycle.
- Each cycle of `col_ready_i`=0 in HOLD adds exactly one cycle. No reads are issued in HOLD.
- `col_ready_i` high while `col_valid_o` is low has no effect.

## Structure
- Shared package `me_pkg`:
  - BIT_DEPTH, COL_PIXELS, NUM_COLS
  - COL_WIDTH = COL_PIXELS*BIT_DEPTH (184)
  - state encoding for IDLE/FETCH/HOLD/DONE
- Sub-module `ref_addr_gen`: holds the r/c counters, the latched x0/y0, and the address add. It exposes `last_row` and `last_col` flags to the FSM.
- The top level holds the FSM, the one-cycle read-data valid delay, the column shift register, and the output handshake.

## Test plan
- Reset, then x0=0, y0=0 with memory[a]=a[7:0] and ready held high:
  - column 0 = {8'h00, 8'h40, 8'h80, 8'hC0, …} (row stride 64).
  - 23 columns are emitted with `col_index_o` 0..22.
  - `done_o` pulses 576 cycles after start.
- x0=5, y0=3: first address 197, last address (25<<6)+27 = 1627. Check every `mem_addr_o` against the formula.
- Backpressure: hold `col_ready_i` low for 7 cycles on column 4.
  - `col_data_o` stays stable and no reads occur.
  - Total latency grows by exactly 7.
- `start_i` pulsed during FETCH and during DONE: ignored. A second window starts only on `start_i` in IDLE.
- Assert `rst_i` mid-FETCH of column 10:
  - all outputs 0 immediately, state IDLE.
  - A fresh start emits column 0 correctly with no stale pixels.
- Random ready toggling over a full window: the scoreboarded columns match a reference model bit-exactly.

Source files
------------

// File: rtl/ref_column_feeder_pkg.sv
// Shared motion-estimation constants, the feeder state encoding and the
// reference-frame address helper used by the column feeder.
package me_pkg;

    // Pixel and window geometry.
    localparam int BIT_DEPTH        = 8;
    localparam int COL_PIXELS       = 23;
    localparam int NUM_COLS         = 23;
    localparam int COL_WIDTH        = COL_PIXELS * BIT_DEPTH;

    // Reference frame memory geometry (64 pixels per row).
    localparam int FRAME_WIDTH_LOG2 = 6;
    localparam int ADDR_WIDTH       = 12;
    localparam int ROW_WIDTH        = ADDR_WIDTH - FRAME_WIDTH_LOG2;

    // Row and column counters both need to reach 23.
    localparam int IDX_WIDTH        = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_e;

    // Linear address of pixel (r, c) of a window whose top-left corner is
    // (x0, y0). The row sum wraps inside the row field and the column term
    // carries into it, so the whole result is modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] pixel_addr(
        input logic [FRAME_WIDTH_LOG2-1:0] x0,
        input logic [ROW_WIDTH-1:0]        y0,
        input logic [IDX_WIDTH-1:0]        r,
        input logic [IDX_WIDTH-1:0]        c
    );
        logic [ROW_WIDTH-1:0]  row;
        logic [ADDR_WIDTH-1:0] row_base;
        row      = y0 + ROW_WIDTH'(r);
        row_base = {row, {FRAME_WIDTH_LOG2{1'b0}}};
        return row_base + ADDR_WIDTH'(x0) + ADDR_WIDTH'(c);
    endfunction

endpackage

// File: rtl/ref_column_feeder_if.sv
// Control, frame-memory read and column-output signals of the reference
// column feeder. The feeder side uses the master modport; whatever drives
// the start command, serves memory reads and sinks columns uses the slave.
interface ref_column_feeder_if;
    import me_pkg::*;

    // Window command and status.
    logic                        start_i;
    logic [FRAME_WIDTH_LOG2-1:0] x0_i;
    logic [ROW_WIDTH-1:0]        y0_i;
    logic                        busy_o;
    logic                        done_o;

    // Frame memory read port (data returns one cycle after the strobe).
    logic                        mem_rd_en_o;
    logic [ADDR_WIDTH-1:0]       mem_addr_o;
    logic [BIT_DEPTH-1:0]        mem_data_i;

    // Column stream towards the reference FIFO.
    logic                        col_valid_o;
    logic                        col_ready_i;
    logic [COL_WIDTH-1:0]        col_data_o;
    logic [IDX_WIDTH-1:0]        col_index_o;

    modport master (
        input  start_i, x0_i, y0_i, mem_data_i, col_ready_i,
        output busy_o, done_o, mem_rd_en_o, mem_addr_o,
               col_valid_o, col_data_o, col_index_o
    );

    modport slave (
        output start_i, x0_i, y0_i, mem_data_i, col_ready_i,
        input  busy_o, done_o, mem_rd_en_o, mem_addr_o,
               col_valid_o, col_data_o, col_index_o
    );

endinterface

// File: rtl/ref_column_feeder_addr_gen.sv
// Window address generator: latches the window origin, walks the row and
// column counters and forms the frame memory read address.
module ref_addr_gen
    import me_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        load,
    input  logic                        row_inc,
    input  logic                        col_next,
    input  logic [FRAME_WIDTH_LOG2-1:0] x0,
    input  logic [ROW_WIDTH-1:0]        y0,
    output logic [ADDR_WIDTH-1:0]       addr,
    output logic [IDX_WIDTH-1:0]        col_index,
    output logic                        last_row,
    output logic                        rows_done,
    output logic                        last_col
);

    logic [FRAME_WIDTH_LOG2-1:0] x0_q;
    logic [ROW_WIDTH-1:0]        y0_q;
    logic [IDX_WIDTH-1:0]        row_q;
    logic [IDX_WIDTH-1:0]        col_q;

    // Origin latch plus row/column walk; a new column restarts at row 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x0_q  <= '0;
            y0_q  <= '0;
            row_q <= '0;
            col_q <= '0;
        end else if (load) begin
            x0_q  <= x0;
            y0_q  <= y0;
            row_q <= '0;
            col_q <= '0;
        end else if (col_next) begin
            col_q <= col_q + IDX_WIDTH'(1);
            row_q <= '0;
        end else if (row_inc) begin
            row_q <= row_q + IDX_WIDTH'(1);
        end
    end

    assign addr      = pixel_addr(x0_q, y0_q, row_q, col_q);
    assign col_index = col_q;
    assign last_row  = (row_q == IDX_WIDTH'(COL_PIXELS - 1));
    assign rows_done = (row_q == IDX_WIDTH'(COL_PIXELS));
    assign last_col  = (col_q == IDX_WIDTH'(NUM_COLS - 1));

endmodule

// File: rtl/ref_column_feeder.sv
// Reference-window column streamer: reads a 23x23 search window one pixel
// per cycle, packs each vertical column into one word (row 0 in the top
// byte) and offers the columns left to right over a valid/ready handshake.
module ref_column_feeder
    import me_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    ref_column_feeder_if.master bus
);

    feeder_state_e          state_q;
    feeder_state_e          state_d;

    logic                   load;
    logic                   col_next;
    logic                   rd_en;
    logic                   last_row;
    logic                   rows_done;
    logic                   last_col;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [IDX_WIDTH-1:0]   col_index;

    // Read pipeline: marks the cycle in which memory data is on mem_data_i,
    // and whether that pixel is the bottom row of the column.
    logic                   rd_valid_q;
    logic                   rd_last_q;
    logic                   pixel_last;

    logic [COL_WIDTH-1:0]   col_sr_q;

    ref_addr_gen u_addr_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load      (load),
        .row_inc   (rd_en),
        .col_next  (col_next),
        .x0        (bus.x0_i),
        .y0        (bus.y0_i),
        .addr      (addr),
        .col_index (col_index),
        .last_row  (last_row),
        .rows_done (rows_done),
        .last_col  (last_col)
    );

    // Reads are issued only while fetching and until all rows are requested.
    assign rd_en      = (state_q == ST_FETCH) && !rows_done;
    assign pixel_last = rd_valid_q && rd_last_q;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and counter control; start is honoured only in IDLE.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        col_next = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    load    = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (pixel_last) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.col_ready_i) begin
                    if (last_col) begin
                        state_d = ST_DONE;
                    end else begin
                        col_next = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One-cycle delay matching the memory read latency; reset drops any
    // pixel still in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            rd_last_q  <= rd_en && last_row;
        end
    end

    // Column assembly: each returned pixel enters at the low byte so the
    // first row fetched ends up in the most significant byte.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_sr_q <= '0;
        end else if (rd_valid_q) begin
            col_sr_q <= {col_sr_q[COL_WIDTH-BIT_DEPTH-1:0], bus.mem_data_i};
        end
    end

    assign bus.busy_o      = (state_q != ST_IDLE);
    assign bus.done_o      = (state_q == ST_DONE);
    assign bus.mem_rd_en_o = rd_en;
    assign bus.mem_addr_o  = addr;
    assign bus.col_valid_o = (state_q == ST_HOLD);
    assign bus.col_data_o  = col_sr_q;
    assign bus.col_index_o = col_index;

endmodule

// File: tb/tb_ref_column_feeder.sv
// Bench for the reference column feeder: a frame memory model, a window
// reference model built from the address formula and byte placement rule,
// a negedge monitor/scoreboard, a vector table and a few hand sequences.
module tb_ref_column_feeder;
    import me_pkg::*;

    localparam int WIN_READS    = COL_PIXELS * NUM_COLS;
    localparam int NOSTALL_DONE = NUM_COLS * 25 + 1;
    localparam int RUN_LIMIT    = 3000;

    typedef struct {
        int          x0;
        int          y0;
        int          stall_col;
        int          stall_len;
        bit          poke;
        int          exp_first;
        int          exp_last;
        int          exp_done;
        logic [31:0] exp_top;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   compared;
    int   mismatched;

    logic [7:0] mem [0:4095];

    bit                   mon_en;
    int                   win_x0;
    int                   win_y0;
    int                   rd_cnt;
    int                   xfer_cnt;
    int                   stalls;
    int                   first_addr;
    int                   last_addr;
    int                   done_edge;
    logic [COL_WIDTH-1:0] col0_data;
    bit                   prev_hold;
    logic [COL_WIDTH-1:0] prev_data;
    logic [IDX_WIDTH-1:0] prev_idx;

    vec_t vecs [4];

    ref_column_feeder_if bus ();

    ref_column_feeder dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Frame memory: one-cycle read latency, noise whenever no read is issued.
    always @(posedge clk) begin
        if (bus.mem_rd_en_o) bus.mem_data_i <= mem[bus.mem_addr_o];
        else                 bus.mem_data_i <= 8'($urandom);
    end

    task automatic checkOutput(input string name, input logic [COL_WIDTH-1:0] actual,
                               input logic [COL_WIDTH-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    function automatic int model_addr(int x0, int y0, int r, int c);
        return ((y0 + r) * 64 + x0 + c) % 4096;
    endfunction

    function automatic logic [COL_WIDTH-1:0] model_col(int x0, int y0, int c);
        logic [COL_WIDTH-1:0] w;
        w = '0;
        for (int r = 0; r < COL_PIXELS; r++)
            w[COL_WIDTH-1-8*r -: 8] = mem[model_addr(x0, y0, r, c)];
        return w;
    endfunction

    task automatic fill_mem(input bit random_fill);
        for (int a = 0; a < 4096; a++)
            mem[a] = random_fill ? 8'($urandom) : 8'(a);
    endtask

    // Scoreboard: addresses in row/column order, no reads while a column is
    // offered, stable held words, and every transferred column vs the model.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_rd_en_o) begin
                checkOutput("mem_addr", COL_WIDTH'(bus.mem_addr_o),
                            COL_WIDTH'(model_addr(win_x0, win_y0, rd_cnt % COL_PIXELS,
                                                  rd_cnt / COL_PIXELS)));
                if (rd_cnt == 0) first_addr = int'(bus.mem_addr_o);
                last_addr = int'(bus.mem_addr_o);
                rd_cnt++;
            end
            if (bus.col_valid_o) begin
                checkOutput("no_read_in_hold", COL_WIDTH'(bus.mem_rd_en_o), '0);
                if (prev_hold) begin
                    checkOutput("hold_data_stable", bus.col_data_o, prev_data);
                    checkOutput("hold_index_stable", COL_WIDTH'(bus.col_index_o),
                                COL_WIDTH'(prev_idx));
                end
                if (bus.col_ready_i) begin
                    checkOutput("col_index", COL_WIDTH'(bus.col_index_o), COL_WIDTH'(xfer_cnt));
                    checkOutput("col_data", bus.col_data_o, model_col(win_x0, win_y0, xfer_cnt));
                    if (xfer_cnt == 0) col0_data = bus.col_data_o;
                    xfer_cnt++;
                    prev_hold = 1'b0;
                end else begin
                    stalls++;
                    prev_hold = 1'b1;
                    prev_data = bus.col_data_o;
                    prev_idx  = bus.col_index_o;
                end
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    // Runs one window: optional fixed stall on one column, random ready, or
    // start pokes during FETCH and in the DONE cycle.
    task automatic applyStimulus(input int x0, input int y0, input int stall_col,
                                 input int stall_len, input bit rand_ready, input bit poke);
        int start_cyc;
        int n;
        int stall_rem;
        bit stalled;
        bit finished;
        @(posedge clk); #1;
        win_x0 = x0; win_y0 = y0;
        rd_cnt = 0; xfer_cnt = 0; stalls = 0; prev_hold = 1'b0;
        first_addr = -1; last_addr = -1; done_edge = -1; col0_data = '0;
        bus.x0_i = 6'(x0); bus.y0_i = 6'(y0);
        bus.start_i = 1'b1; bus.col_ready_i = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        bus.start_i = 1'b0;
        bus.x0_i = ~bus.x0_i;
        bus.y0_i = ~bus.y0_i;
        checkOutput("busy_after_start", COL_WIDTH'(bus.busy_o), COL_WIDTH'(1));
        stall_rem = 0; stalled = 1'b0; finished = 1'b0;
        for (int k = 0; k < RUN_LIMIT && !finished; k++) begin
            @(posedge clk); #1;
            n = cyc - start_cyc;
            if (poke && n == 5) bus.start_i = 1'b1;
            else if (poke && n == 6) bus.start_i = 1'b0;
            if (rand_ready) begin
                bus.col_ready_i = ($urandom_range(0, 3) != 0);
            end else if (stall_rem > 0) begin
                stall_rem--;
            end else if (!stalled && stall_len > 0 && bus.col_valid_o &&
                         bus.col_index_o == 5'(stall_col)) begin
                stalled = 1'b1;
                bus.col_ready_i = 1'b0;
                stall_rem = stall_len - 1;
            end else begin
                bus.col_ready_i = 1'b1;
            end
            if (bus.done_o) begin
                done_edge = n + 1;
                finished = 1'b1;
                checkOutput("busy_at_done", COL_WIDTH'(bus.busy_o), COL_WIDTH'(1));
                if (poke) bus.start_i = 1'b1;
            end
        end
        if (!finished) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL window_timeout: got no done_o within %0d cycles required done_o",
                     RUN_LIMIT);
            mon_en = 1'b0;
            bus.start_i = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        @(posedge clk); #1;
        checkOutput("done_one_cycle", COL_WIDTH'(bus.done_o), '0);
        checkOutput("idle_after_done", COL_WIDTH'(bus.busy_o), '0);
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        checkOutput("start_in_done_ignored", COL_WIDTH'(bus.busy_o), '0);
        mon_en = 1'b0;
        checkOutput("columns_sent", COL_WIDTH'(xfer_cnt), COL_WIDTH'(NUM_COLS));
        checkOutput("reads_issued", COL_WIDTH'(rd_cnt), COL_WIDTH'(WIN_READS));
        checkOutput("done_latency", COL_WIDTH'(done_edge), COL_WIDTH'(NOSTALL_DONE + stalls));
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_busy"},  COL_WIDTH'(bus.busy_o),      '0);
        checkOutput({tag, "_done"},  COL_WIDTH'(bus.done_o),      '0);
        checkOutput({tag, "_rd_en"}, COL_WIDTH'(bus.mem_rd_en_o), '0);
        checkOutput({tag, "_addr"},  COL_WIDTH'(bus.mem_addr_o),  '0);
        checkOutput({tag, "_valid"}, COL_WIDTH'(bus.col_valid_o), '0);
        checkOutput({tag, "_data"},  bus.col_data_o,              '0);
        checkOutput({tag, "_index"}, COL_WIDTH'(bus.col_index_o), '0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of test required end within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int rx0;
        int ry0;
        cyc = 0; compared = 0; mismatched = 0; mon_en = 1'b0;
        bus.start_i = 1'b0; bus.x0_i = '0; bus.y0_i = '0;
        bus.col_ready_i = 1'b1; bus.mem_data_i = '0;
        rst = 1'b1;

        // x0, y0, stall column, stall length, poke start, first addr, last addr,
        // done edge, top four bytes of column 0 with memory[a] = a[7:0]
        vecs[0] = '{0,  0,  0,  0, 1'b1, 0,    1430, 576, 32'h004080C0};
        vecs[1] = '{5,  3,  4,  7, 1'b0, 197,  1627, 583, 32'hC5054585};
        vecs[2] = '{41, 0,  22, 3, 1'b0, 41,   1471, 579, 32'h2969A9E9};
        vecs[3] = '{20, 30, 0,  1, 1'b0, 1940, 3370, 577, 32'h94D41454};

        #22;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        fill_mem(1'b0);
        for (int i = 0; i < 4; i++) begin
            $display("[TB] window x0=%0d y0=%0d stall=%0d", vecs[i].x0, vecs[i].y0, vecs[i].stall_len);
            applyStimulus(vecs[i].x0, vecs[i].y0, vecs[i].stall_col, vecs[i].stall_len,
                          1'b0, vecs[i].poke);
            checkOutput("first_addr", COL_WIDTH'(first_addr), COL_WIDTH'(vecs[i].exp_first));
            checkOutput("last_addr",  COL_WIDTH'(last_addr),  COL_WIDTH'(vecs[i].exp_last));
            checkOutput("done_edge",  COL_WIDTH'(done_edge),  COL_WIDTH'(vecs[i].exp_done));
            checkOutput("col0_top",   COL_WIDTH'(col0_data[COL_WIDTH-1 -: 32]),
                        COL_WIDTH'(vecs[i].exp_top));
        end

        // Reset in the middle of fetching column 10.
        $display("[TB] reset during column 10");
        fill_mem(1'b1);
        @(posedge clk); #1;
        bus.x0_i = 6'd2; bus.y0_i = 6'd2; bus.start_i = 1'b1; bus.col_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        waited = 0;
        while (!(bus.col_index_o == 5'd10 && bus.mem_rd_en_o) && waited < RUN_LIMIT) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= RUN_LIMIT) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL reach_col10: got no fetch of column 10 required fetch");
        end
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(7, 9, 0, 0, 1'b0, 1'b0);

        // Random windows and random ready against the reference model.
        for (int i = 0; i < 2; i++) begin
            rx0 = $urandom_range(0, 41);
            ry0 = $urandom_range(0, 41);
            $display("[TB] random window x0=%0d y0=%0d", rx0, ry0);
            fill_mem(1'b1);
            applyStimulus(rx0, ry0, 0, 0, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
